serial_word_receiver: RTL

SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

---
 rtl/serial_word_receiver.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
//   Deserialises a framed bit stream into N-bit words. A bit qualified by
//   serial_valid together with frame_start opens a word; the N-th bit closes it
//   and hands the word to a one-deep valid/ready output register. Bit order is
//   chosen per word by dir, sampled with the first bit.
//
// Ports
//   clock         : single clock, rising edge
//   reset_n       : asynchronous active-low reset
//   serial_in     : serial data bit
//   serial_valid  : serial_in carries a valid bit this cycle
//   frame_start   : current valid bit is bit 0 of a new word
//   dir           : 0 = MSB first, 1 = LSB first (sampled with the first bit)
//   flags_clr     : synchronous clear of overrun / frame_error
//   out_ready     : consumer accepts parallel_out
//   parallel_out  : last completed word
//   out_valid     : parallel_out holds an unconsumed word
//   busy          : a word is partially received
//   bit_count     : bits received in the current word
//   overrun       : sticky, a completed word was dropped
//   frame_error   : sticky, a word was aborted by an early frame_start
// -----------------------------------------------------------------------------
module serial_word_receiver #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          serial_in,
    input  logic          serial_valid,
    input  logic          frame_start,
    input  logic          dir,
    input  logic          flags_clr,
    input  logic          out_ready,
    output logic [N-1:0]  parallel_out,
    output logic          out_valid,
    output logic          busy,
    output logic [CW-1:0] bit_count,
    output logic          overrun,
    output logic          frame_error
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t        state_r;
    logic [N-1:0]  shift_r;
    logic [N-1:0]  parallel_out_r;
    logic [CW-1:0] bit_count_r;
    logic          dir_r;
    logic          out_valid_r;
    logic          overrun_r;
    logic          frame_error_r;

    logic [N-1:0]  base_s;
    logic [N-1:0]  shifted_s;
    logic          shift_dir_s;
    logic          start_s;
    logic          restart_s;
    logic          last_bit_s;
    logic          word_done_s;
    logic          accept_s;
    logic          overrun_set_s;

    // Next shift-register value and word-completion / flag-set decode
    always_comb begin
        start_s       = serial_valid & frame_start;
        restart_s     = start_s & (state_r == RECV);
        last_bit_s    = (bit_count_r == CW'(N - 1));
        word_done_s   = serial_valid & ~frame_start & (state_r == RECV) & last_bit_s;
        accept_s      = ~out_valid_r | out_ready;
        overrun_set_s = word_done_s & ~accept_s;
        // A first bit uses the freshly presented dir and starts from an empty
        // register so nothing of an aborted word survives.
        if (start_s) begin
            shift_dir_s = dir;
            base_s      = {N{1'b0}};
        end else begin
            shift_dir_s = dir_r;
            base_s      = shift_r;
        end
        if (shift_dir_s) begin
            shifted_s = {serial_in, base_s[N-1:1]};
        end else begin
            shifted_s = {base_s[N-2:0], serial_in};
        end
    end

    // Receive FSM: state, shift register, bit counter and latched bit order
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            shift_r     <= {N{1'b0}};
            bit_count_r <= {CW{1'b0}};
            dir_r       <= 1'b0;
        end else if (serial_valid) begin
            case (state_r)
                IDLE: begin
                    if (frame_start) begin
                        state_r     <= RECV;
                        dir_r       <= dir;
                        shift_r     <= shifted_s;
                        bit_count_r <= CW'(1);
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                RECV: begin
                    if (frame_start) begin
                        dir_r       <= dir;
                        shift_r     <= shifted_s;
                        bit_count_r <= CW'(1);
                    end else if (last_bit_s) begin
                        state_r     <= IDLE;
                        shift_r     <= shifted_s;
                        bit_count_r <= {CW{1'b0}};
                    end else begin
                        shift_r     <= shifted_s;
                        bit_count_r <= bit_count_r + CW'(1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    bit_count_r <= {CW{1'b0}};
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Output register with valid/ready handshake; a completing word may
    // replace a word being consumed on the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parallel_out_r <= {N{1'b0}};
            out_valid_r    <= 1'b0;
        end else if (word_done_s && accept_s) begin
            parallel_out_r <= shifted_s;
            out_valid_r    <= 1'b1;
        end else if (out_valid_r && out_ready && !word_done_s) begin
            out_valid_r    <= 1'b0;
        end else begin
            out_valid_r    <= out_valid_r;
        end
    end

    // Sticky flags; a set event in the same cycle wins over flags_clr
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r     <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            overrun_r     <= overrun_set_s | (overrun_r & ~flags_clr);
            frame_error_r <= restart_s | (frame_error_r & ~flags_clr);
        end
    end

    assign parallel_out = parallel_out_r;
    assign out_valid    = out_valid_r;
    assign busy         = (state_r == RECV);
    assign bit_count    = bit_count_r;
    assign overrun      = overrun_r;
    assign frame_error  = frame_error_r;

endmodule
